// File: rtl/event_count_source_if.sv
// Event counter bundle: raw event input, count controls and count outputs.
//   event_in     raw asynchronous event line, active-high
//   clear        synchronous count clear, active-high
//   hold         freeze counting while high
//   count_number current modulo-N count
//   count_valid  1-cycle pulse when count_number changes
//   wrap_pulse   1-cycle pulse on the MODULUS-1 -> 0 step
// master drives the controls (stimulus side); slave is the counter itself.
interface event_count_source_if;
  logic       event_in;
  logic       clear;
  logic       hold;
  logic [3:0] count_number;
  logic       count_valid;
  logic       wrap_pulse;

  modport master (
    output event_in,
    output clear,
    output hold,
    input  count_number,
    input  count_valid,
    input  wrap_pulse
  );

  modport slave (
    input  event_in,
    input  clear,
    input  hold,
    output count_number,
    output count_valid,
    output wrap_pulse
  );
endinterface

// File: rtl/event_count_source.sv
// Event count source: synchronises, debounces and edge-detects a raw event
// line, then keeps a modulo-MODULUS count for the downstream 4-bit comparator.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active-low
//   bus    event_count_source_if.slave (event_in, clear, hold in;
//          count_number, count_valid, wrap_pulse out)
// Parameters:
//   MODULUS          count range 0..MODULUS-1, legal 2..16
//   DEBOUNCE_CYCLES  samples a new level must persist beyond the first, legal >= 1
module event_count_source #(
  parameter int unsigned MODULUS         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  event_count_source_if.slave        bus
);

  localparam int unsigned DcWidth = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DcWidth-1:0] DcMax = DcWidth'(DEBOUNCE_CYCLES);
  localparam logic [DcWidth-1:0] DcOne = DcWidth'(1);
  localparam logic [3:0] MaxCount = 4'(MODULUS - 1);

  typedef enum logic [1:0] {
    StIdleLow,
    StQualHigh,
    StStableHigh,
    StQualLow
  } state_e;

  // Two-flop synchroniser; sync_q[1] is the only view of event_in used below.
  logic [1:0] sync_q;
  logic       s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.event_in};
    end
  end

  assign s = sync_q[1];

  // Debounce FSM: state register.
  state_e             state_q, state_d;
  logic [DcWidth-1:0] dc_q, dc_d;
  logic               rise_d, rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdleLow;
      dc_q    <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
      rise_q  <= rise_d;
    end
  end

  // Debounce FSM: next state. dc counts consecutive samples at the candidate level.
  always_comb begin
    state_d = state_q;
    dc_d    = dc_q;
    unique case (state_q)
      StIdleLow: begin
        if (s) begin
          state_d = StQualHigh;
          dc_d    = DcOne;
        end
      end
      StQualHigh: begin
        if (!s) begin
          state_d = StIdleLow;
          dc_d    = '0;
        end else if (dc_q == DcMax) begin
          state_d = StStableHigh;
          dc_d    = '0;
        end else begin
          dc_d = dc_q + DcOne;
        end
      end
      StStableHigh: begin
        if (!s) begin
          state_d = StQualLow;
          dc_d    = DcOne;
        end
      end
      StQualLow: begin
        if (s) begin
          state_d = StStableHigh;
          dc_d    = '0;
        end else if (dc_q == DcMax) begin
          state_d = StIdleLow;
          dc_d    = '0;
        end else begin
          dc_d = dc_q + DcOne;
        end
      end
      default: begin
        state_d = StIdleLow;
        dc_d    = '0;
      end
    endcase
  end

  // Debounce FSM: output. Only a fresh qualification counts as an event;
  // returning to StStableHigh from a rejected low glitch does not.
  always_comb begin
    rise_d = 1'b0;
    if ((state_q == StQualHigh) && (state_d == StStableHigh)) begin
      rise_d = 1'b1;
    end
  end

  // Modulo counter with clear > event > hold-value priority.
  logic [3:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
      valid_d = (count_q != 4'd0);
    end else if (rise_q && !bus.hold) begin
      valid_d = 1'b1;
      if (count_q == MaxCount) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count_number = count_q;
  assign bus.count_valid  = valid_q;
  assign bus.wrap_pulse   = wrap_q;

endmodule
